// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares an async SRAM between CPU and debug ports and sequences its active-low strobes
module sram_access_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int WAIT_CYCLES = 2,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic              busy,
  output logic              owner
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic we;
  logic cpu_win;
  always_comb cpu_win = cpu_req & (~dbg_req | (ROUND_ROBIN == 0) | owner);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      we <= 1'b0;
      {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE} <= 5'b11111;
      Mem_ADDR <= '0;
      Data_to_SRAM <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      cpu_done <= 1'b0;
      dbg_done <= 1'b0;
      busy <= 1'b0;
      owner <= 1'b1;
    end else begin
      case (state)
        IDLE: if (cpu_req | dbg_req) begin
          state <= SETUP;
          busy <= 1'b1;
          owner <= ~cpu_win;
          we <= cpu_win ? cpu_we : dbg_we;
          Mem_ADDR <= cpu_win ? cpu_addr : dbg_addr;
          Data_to_SRAM <= cpu_win ? cpu_wdata : dbg_wdata;
          {Mem_CE, Mem_UB, Mem_LB} <= 3'b000;
          Mem_OE <= cpu_win ? cpu_we : dbg_we;
        end
        SETUP: begin
          state <= ACCESS;
          cnt <= 4'(WAIT_CYCLES - 1);
          Mem_WE <= ~we;
        end
        ACCESS: if (cnt == '0) begin
          state <= DONE;
          Mem_OE <= 1'b1;
          Mem_WE <= 1'b1;
          cpu_done <= ~owner;
          dbg_done <= owner;
          if (!we && owner) dbg_rdata <= Data_from_SRAM;
          if (!we && !owner) cpu_rdata <= Data_from_SRAM;
        end else begin
          cnt <= cnt - 4'd1;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          {Mem_CE, Mem_UB, Mem_LB} <= 3'b111;
          cpu_done <= 1'b0;
          dbg_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter: table-driven, hand-sequenced and randomized model checks of sram_access_arbiter
module tb_sram_access_arbiter;
  localparam int W = 2;
  logic Clk = 1'b0, Reset = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0, c1_req = 1'b0, d1_req = 1'b0;
  logic [19:0] cpu_addr = '0, dbg_addr = '0;
  logic [15:0] cpu_wdata = '0, dbg_wdata = '0;
  logic [15:0] cpu_rdata, dbg_rdata, Data_to_SRAM, Data_from_SRAM;
  logic cpu_done, dbg_done, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, busy, owner;
  logic [19:0] Mem_ADDR, b_addr;
  logic [15:0] b_cpu_rdata, b_dbg_rdata, b_dout;
  logic b_cpu_done, b_dbg_done, b_ce, b_ub, b_lb, b_oe, b_we, b_busy, b_owner;
  logic [15:0] mem [0:1023];
  bit valid [0:1023];
  int checks = 0, errors = 0;
  bit inv_on = 1'b0;
  typedef struct {bit port; bit we; logic [19:0] addr; logic [15:0] wdata; logic [15:0] rdata;} tv_t;
  tv_t tv [8];
  logic [15:0] shadow [int];

  always #5 Clk = ~Clk;

  sram_access_arbiter #(.WAIT_CYCLES(W), .ROUND_ROBIN(1)) u0 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .Mem_ADDR(Mem_ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
    .busy(busy), .owner(owner));

  sram_access_arbiter #(.WAIT_CYCLES(W), .ROUND_ROBIN(0)) u1 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(c1_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_done(b_cpu_done),
    .dbg_req(d1_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(b_dbg_rdata), .dbg_done(b_dbg_done),
    .Mem_CE(b_ce), .Mem_UB(b_ub), .Mem_LB(b_lb), .Mem_OE(b_oe), .Mem_WE(b_we),
    .Mem_ADDR(b_addr), .Data_to_SRAM(b_dout), .Data_from_SRAM(16'h0000),
    .busy(b_busy), .owner(b_owner));

  function automatic logic [15:0] f(input logic [9:0] a);
    return a == 10'h010 ? 16'h1234 : {6'h2A, a};
  endfunction

  always @(posedge Clk) if (!Mem_CE && !Mem_WE) begin
    mem[Mem_ADDR[9:0]] <= Data_to_SRAM;
    valid[Mem_ADDR[9:0]] <= 1'b1;
  end
  always_comb Data_from_SRAM = (!Mem_CE && !Mem_OE) ? (valid[Mem_ADDR[9:0]] ? mem[Mem_ADDR[9:0]] : f(Mem_ADDR[9:0])) : 16'h0000;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, x, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
    if (inv_on) begin
      chk("inv_u0", {~Mem_WE & ~Mem_OE, ~Mem_WE & Mem_CE, Mem_UB ^ Mem_CE, Mem_LB ^ Mem_CE, busy ^ ~Mem_CE}, 0);
      chk("inv_u1", {~b_we & ~b_oe, ~b_we & b_ce, b_ub ^ b_ce, b_lb ^ b_ce, b_busy ^ ~b_ce}, 0);
    end
  endtask

  task automatic wait_done(input bit inst, output int port, output int n);
    n = 0;
    port = 2;
    while (port == 2 && n < 4 * (W + 3)) begin
      tick();
      n++;
      if (inst ? b_cpu_done : cpu_done) port = 0;
      else if (inst ? b_dbg_done : dbg_done) port = 1;
    end
  endtask

  task automatic do_access(input tv_t v);
    if (v.port) {dbg_req, dbg_we, dbg_addr, dbg_wdata} = {1'b1, v.we, v.addr, v.wdata};
    else {cpu_req, cpu_we, cpu_addr, cpu_wdata} = {1'b1, v.we, v.addr, v.wdata};
    for (int c = 1; c <= W + 3; c++) begin
      tick();
      chk("strobes", {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE},
          {{3{c > W + 2}}, !(!v.we && c <= W + 1), !(v.we && c >= 2 && c <= W + 1)});
      chk("mem_addr", Mem_ADDR, v.addr);
      chk("done", {cpu_done, dbg_done}, c == W + 2 ? (v.port ? 2'b01 : 2'b10) : 2'b00);
      chk("busy", busy, c <= W + 2);
      if (c == 1) begin
        if (v.port) {dbg_we, dbg_addr, dbg_wdata} = {~v.we, ~v.addr, ~v.wdata};
        else {cpu_we, cpu_addr, cpu_wdata} = {~v.we, ~v.addr, ~v.wdata};
      end
      if (c == W + 2) begin
        chk("rdata", v.port ? dbg_rdata : cpu_rdata, v.rdata);
        chk("owner", owner, v.port);
        if (v.we) chk("wdata", Data_to_SRAM, v.wdata);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
      end
    end
  endtask

  initial begin
    int p, n, e, free_at, done_at;
    bit win, last, gwe;
    logic [19:0] gaddr;
    logic [15:0] gw, rexp;
    logic [19:0] a6 [4];
    logic [15:0] x6 [4];
    tv[0] = '{1'b0, 1'b1, 20'h0003A, 16'hBEEF, 16'h0000};
    tv[1] = '{1'b0, 1'b0, 20'h00010, 16'h0000, 16'h1234};
    tv[2] = '{1'b0, 1'b0, 20'h0003A, 16'h0000, 16'hBEEF};
    tv[3] = '{1'b1, 1'b1, 20'h00055, 16'hCAFE, 16'h0000};
    tv[4] = '{1'b1, 1'b0, 20'h00055, 16'h0000, 16'hCAFE};
    tv[5] = '{1'b1, 1'b1, 20'h0003A, 16'h0F0F, 16'hCAFE};
    tv[6] = '{1'b0, 1'b0, 20'h0003A, 16'h0000, 16'h0F0F};
    tv[7] = '{1'b1, 1'b0, 20'h00010, 16'h0000, 16'h1234};
    a6 = '{20'h00010, 20'h0003A, 20'h00055, 20'h00200};
    x6 = '{16'h1234, 16'h0F0F, 16'hCAFE, f(10'h200)};
    @(negedge Clk);
    repeat (3) tick();
    chk("rst_strobes", {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}, 5'h1F);
    chk("rst_busy_done", {busy, cpu_done, dbg_done}, 3'b000);
    chk("rst_rdata", {cpu_rdata, dbg_rdata}, 32'h0);
    chk("rst_owner", owner, 1'b1);
    Reset = 1'b0;
    inv_on = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) do_access(tv[i]);
    {cpu_we, dbg_we, cpu_req, dbg_req} = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      wait_done(1'b0, p, n);
      chk("rr_order", p, i % 2);
    end
    {cpu_req, dbg_req} = 2'b00;
    tick();
    {c1_req, d1_req} = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wait_done(1'b1, p, n);
      chk("fixed_order", p, i == 2);
      if (i == 1) c1_req = 1'b0;
    end
    d1_req = 1'b0;
    tick();
    {cpu_req, cpu_we, cpu_addr, cpu_wdata} = {1'b1, 1'b1, 20'h00077, 16'h1111};
    repeat (3) tick();
    chk("abort_we_low", Mem_WE, 1'b0);
    Reset = 1'b1;
    cpu_req = 1'b0;
    tick();
    chk("abort_strobes", {Mem_CE, Mem_WE, busy, cpu_done}, 4'b1100);
    Reset = 1'b0;
    tick();
    chk("abort_no_done", {busy, cpu_done}, 2'b00);
    do_access('{1'b0, 1'b0, 20'h0003A, 16'h0000, 16'h0F0F});
    {dbg_we, dbg_addr, dbg_req} = {1'b0, a6[0], 1'b1};
    for (int i = 0; i < 4; i++) begin
      wait_done(1'b0, p, n);
      chk("stream_port", p, 1);
      chk("stream_gap", n, i == 0 ? W + 2 : W + 3);
      chk("stream_rdata", dbg_rdata, x6[i]);
      if (i < 3) dbg_addr = a6[i + 1];
    end
    dbg_req = 1'b0;
    tick();
    e = 0;
    free_at = 0;
    done_at = -1;
    last = owner;
    win = 1'b0;
    gwe = 1'b0;
    rexp = '0;
    repeat (600) begin
      if (!cpu_req && $urandom_range(2) == 0)
        {cpu_req, cpu_we, cpu_addr, cpu_wdata} = {1'b1, 1'($urandom_range(1)), 20'h00100 + 20'($urandom_range(7)), 16'($urandom)};
      if (!dbg_req && $urandom_range(2) == 0)
        {dbg_req, dbg_we, dbg_addr, dbg_wdata} = {1'b1, 1'($urandom_range(1)), 20'h00100 + 20'($urandom_range(7)), 16'($urandom)};
      e++;
      if (e >= free_at && (cpu_req || dbg_req)) begin
        win = (cpu_req && dbg_req) ? !last : dbg_req;
        last = win;
        done_at = e + W + 1;
        free_at = e + W + 3;
        {gwe, gaddr, gw} = win ? {dbg_we, dbg_addr, dbg_wdata} : {cpu_we, cpu_addr, cpu_wdata};
        rexp = shadow.exists(int'(gaddr)) ? shadow[int'(gaddr)] : f(gaddr[9:0]);
        if (gwe) shadow[int'(gaddr)] = gw;
      end
      tick();
      chk("rand_done", {cpu_done, dbg_done}, e == done_at ? (win ? 2'b01 : 2'b10) : 2'b00);
      chk("rand_busy", busy, e <= done_at);
      if (e == done_at) begin
        if (!gwe) chk("rand_rdata", win ? dbg_rdata : cpu_rdata, rexp);
        if (win) dbg_req = 1'b0;
        else cpu_req = 1'b0;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
